// File: rtl/square_root_datapath.sv
// Iterative restoring integer square root, one root bit per clock.
// Driven by the square-root control FSM through its 2-bit state code; returns the
// iteration count k so the FSM knows when to leave LOOP.
// Optional feature: define SQRT_ROUND_EN to round root_o to nearest (saturating);
// remainder_o always carries the floor remainder.
module square_root_datapath #(
    parameter int N  = 16,
    parameter int KW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [1:0]      state,
    input  logic [2*N-1:0]  radicand_i,
    output logic [KW-1:0]   k,
    output logic [N-1:0]    root_o,
    output logic [N:0]      remainder_o,
    output logic            valid_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_LOOP  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [KW-1:0] K_N   = KW'(N);
    localparam logic [KW-1:0] K_ONE = KW'(1);

    state_t          st;
    logic [2*N-1:0]  rad;
    logic [N+1:0]    rem;
    logic [N-1:0]    root;

    logic [N+1:0]    rem_s;
    logic [N+1:0]    trial;
    logic [N+1:0]    diff;
    logic            fits;
    logic [N-1:0]    final_root;

    // rem never exceeds 2*root, so its top bit only matters to the N+2-bit arithmetic
    logic            unused_rem_msb;
    assign unused_rem_msb = rem[N+1];

    assign st = state_t'(state);

`ifdef SQRT_ROUND_EN
    localparam logic [N-1:0] ROOT_ONE = N'(1);

    // Round to nearest: rem > root means radicand is past (root + 0.5)^2; saturate at all-ones
    function automatic logic [N-1:0] round_root(input logic [N-1:0] r, input logic [N+1:0] rm);
        if ((rm > {2'b00, r}) && (r != '1))
            return r + ROOT_ONE;
        return r;
    endfunction
`endif

    // Trial subtraction for the current root bit and the value presented to root_o at DONE
    always_comb begin
        rem_s = {rem[N-1:0], rad[2*N-1:2*N-2]};
        trial = {root, 2'b01};
        diff  = rem_s - trial;
        fits  = (rem_s >= trial);
`ifdef SQRT_ROUND_EN
        final_root = round_root(root, rem);
`else
        final_root = root;
`endif
    end

    // Iteration registers, iteration counter and result registers
    always_ff @(posedge clk) begin
        if (rst_) begin
            rad         <= '0;
            rem         <= '0;
            root        <= '0;
            k           <= '0;
            root_o      <= '0;
            remainder_o <= '0;
        end else begin
            case (st)
                ST_START: begin
                    rad  <= radicand_i;
                    rem  <= '0;
                    root <= '0;
                    k    <= '0;
                end
                ST_LOOP: begin
                    if (k < K_N) begin
                        rem  <= fits ? diff : rem_s;
                        root <= {root[N-2:0], fits};
                        rad  <= rad << 2;
                        k    <= k + K_ONE;
                    end
                end
                ST_DONE: begin
                    root_o      <= final_root;
                    remainder_o <= rem[N:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags: one-cycle valid after DONE, busy follows START/LOOP by one cycle
    always_ff @(posedge clk) begin
        if (rst_) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            valid_o <= (st == ST_DONE);
            busy_o  <= (st == ST_START) || (st == ST_LOOP);
        end
    end

endmodule

// File: tb/tb_square_root_datapath.sv
// Self-checking bench for square_root_datapath (N = 16). Plays the role of the
// control FSM by driving the state code directly, and compares results against
// an integer square root computed with plain arithmetic.
// Build with +define+SQRT_ROUND_EN to check the rounding variant.
module tb_square_root_datapath;

    localparam int N  = 16;
    localparam int KW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst_;
    logic [1:0]      state;
    logic [2*N-1:0]  radicand_i;
    logic [KW-1:0]   k;
    logic [N-1:0]    root_o;
    logic [N:0]      remainder_o;
    logic            valid_o;
    logic            busy_o;

    int total = 0;
    int bad   = 0;

    square_root_datapath #(.N(N), .KW(KW)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .state       (state),
        .radicand_i  (radicand_i),
        .k           (k),
        .root_o      (root_o),
        .remainder_o (remainder_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // one clock; outputs are sampled 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // floor square root by bitwise search on squares, plus floor remainder
    function automatic void ref_sqrt(input longint unsigned x,
                                     output longint unsigned r,
                                     output longint unsigned rm);
        longint unsigned t;
        r = 0;
        for (int b = N - 1; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        rm = x - r * r;
    endfunction

    function automatic longint unsigned ref_root_out(input longint unsigned x);
        longint unsigned r, rm;
        ref_sqrt(x, r, rm);
`ifdef SQRT_ROUND_EN
        if (rm > r && r < ((64'd1 << N) - 1)) r = r + 1;
`endif
        return r;
    endfunction

    // full operation: START, N+1 LOOP cycles, DONE; optional IDLE cycle afterwards
    task automatic run_op(input logic [2*N-1:0] x, input bit check_k,
                          input bit toggle, input bit idle_after);
        longint unsigned r, rm;
        ref_sqrt(longint'(x), r, rm);
        radicand_i = x;
        state = 2'b01;
        cyc();
        chk("start_k", k, 0);
        chk("start_busy", busy_o, 1);
        chk("start_valid", valid_o, 0);
        state = 2'b10;
        for (int i = 1; i <= N + 1; i++) begin
            if (toggle) radicand_i = $urandom;
            cyc();
            if (check_k) chk($sformatf("loop_k%0d", i), k, (i > N) ? N : i);
        end
        chk("loop_k_end", k, N);
        chk("loop_valid", valid_o, 0);
        chk("loop_busy", busy_o, 1);
        state = 2'b11;
        cyc();
        chk("done_valid", valid_o, 1);
        chk("done_root", root_o, ref_root_out(longint'(x)));
        chk("done_rem", remainder_o, rm);
        chk("done_busy", busy_o, 0);
        if (idle_after) begin
            state = 2'b00;
            radicand_i = $urandom;
            cyc();
            chk("idle_valid", valid_o, 0);
            chk("idle_root_hold", root_o, ref_root_out(longint'(x)));
            chk("idle_rem_hold", remainder_o, rm);
        end
    endtask

    initial begin
        logic [2*N-1:0] x;
        int unsigned    rr;

        // reset state
        rst_ = 1'b1;
        state = 2'b11;
        radicand_i = 32'hDEAD_BEEF;
        cyc();
        cyc();
        chk("rst_k", k, 0);
        chk("rst_root", root_o, 0);
        chk("rst_rem", remainder_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_ = 1'b0;
        state = 2'b00;
        cyc();
        chk("idle_valid0", valid_o, 0);

        // directed cases
        run_op(32'd0, 1'b0, 1'b0, 1'b1);
        run_op(32'd1000000, 1'b1, 1'b0, 1'b1);
        run_op(32'd99, 1'b0, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

        // reset in the middle of LOOP aborts the operation
        radicand_i = 32'd5000;
        state = 2'b01;
        cyc();
        state = 2'b10;
        for (int i = 0; i < 7; i++) cyc();
        chk("mid_k7", k, 7);
        rst_ = 1'b1;
        cyc();
        chk("abort_k", k, 0);
        chk("abort_root", root_o, 0);
        chk("abort_rem", remainder_o, 0);
        chk("abort_valid", valid_o, 0);
        chk("abort_busy", busy_o, 0);
        rst_ = 1'b0;
        state = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("abort_no_valid", valid_o, 0);
        end
        run_op(32'd144, 1'b0, 1'b0, 1'b1);

        // back-to-back with radicand_i changing during LOOP
        run_op(32'd2, 1'b0, 1'b1, 1'b0);
        run_op(32'd3, 1'b0, 1'b1, 1'b1);

        // rounding boundaries: rem == root (no round up) and rem == root + 1
        for (int i = 0; i < 4; i++) begin
            rr = $urandom_range(1, 65534);
            x = 32'(rr * rr + rr);
            run_op(x, 1'b0, 1'b0, 1'b0);
            run_op(x + 32'd1, 1'b0, 1'b0, 1'b1);
        end

        // random operands
        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            if (i % 4 == 0) x = x >> $urandom_range(1, 30);
            run_op(x, 1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
